// File: rtl/elapsed_timer_pkg.sv
// Shared types and default timing constants for the elapsed (up-counting) game timer.
// The display formatter imports the same defaults.
package elapsed_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRunning,
    StPaused,
    StSaturated
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // 65 MHz clock, 100 ms per tick
  localparam logic [24:0] DefaultTickPeriod = 25'd6_500_000;
  localparam logic [13:0] DefaultMaxTenths  = 14'd9999;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single decade counter; carry is combinational so a chain of these ripples in one cycle.
module bcd_digit_counter
  import elapsed_timer_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       clear,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc && (digit_q == 4'd9);

endmodule

// File: rtl/elapsed_timer.sv
// Up-counting stopwatch in 100 ms units with pause/resume, lap capture and saturation.
// Binary and BCD counts advance in lockstep; BCD never needs a conversion step.
module elapsed_timer
  import elapsed_timer_pkg::*;
#(
  parameter logic [24:0] TICK_PERIOD = DefaultTickPeriod,
  parameter logic [13:0] MAX_TENTHS  = DefaultMaxTenths
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        stop_in,
  input  logic        resume_in,
  input  logic        lap_in,
  output logic [13:0] tenths_out,
  output logic [15:0] bcd_out,
  output logic [15:0] lap_bcd_out,
  output logic        running_out,
  output logic        saturated_out,
  output logic        tick_out
);

  state_e      state_q, state_d;
  logic [24:0] presc_q, presc_d;
  logic [13:0] tenths_q, tenths_d;
  logic [15:0] lap_q, lap_d;
  logic        tick_q;
  logic        tick_due;
  logic        fire;
  logic [15:0] bcd;
  logic [3:0]  digit_inc;
  logic [3:0]  digit_carry;
  logic        unused_carry;

  assign tick_due = (presc_q == TICK_PERIOD - 25'd1);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tenths_d = tenths_q;
    fire     = 1'b0;
    if (start_in) begin
      state_d  = StRunning;
      presc_d  = '0;
      tenths_d = '0;
    end else begin
      unique case (state_q)
        StRunning: begin
          if (stop_in) begin
            state_d = StPaused;
            // A stop on the tick cycle parks the prescaler at the boundary,
            // so the deferred tick fires on the first cycle after resume.
            if (!tick_due) presc_d = presc_q + 25'd1;
          end else if (tick_due) begin
            fire     = 1'b1;
            presc_d  = '0;
            tenths_d = tenths_q + 14'd1;
            if (tenths_q + 14'd1 == MAX_TENTHS) state_d = StSaturated;
          end else begin
            presc_d = presc_q + 25'd1;
          end
        end
        StPaused: begin
          if (!stop_in && resume_in) state_d = StRunning;
        end
        StIdle, StSaturated: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Lap samples the registered BCD, i.e. the value before this edge's update.
  assign lap_d = lap_in ? bcd : lap_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      tenths_q <= '0;
      lap_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tenths_q <= tenths_d;
      lap_q    <= lap_d;
      tick_q   <= fire;
    end
  end

  assign digit_inc = {digit_carry[2:0], fire};

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .clear    (start_in),
      .inc      (digit_inc[i]),
      .digit    (bcd[4*i +: 4]),
      .carry    (digit_carry[i])
    );
  end

  assign unused_carry = digit_carry[3];

  assign tenths_out    = tenths_q;
  assign bcd_out       = bcd;
  assign lap_bcd_out   = lap_q;
  assign running_out   = (state_q == StRunning);
  assign saturated_out = (state_q == StSaturated);
  assign tick_out      = tick_q;

endmodule

// File: tb/tb_elapsed_timer.sv
// Directed bench for elapsed_timer: a cycle model checks every output each cycle,
// with hand-computed checkpoints pinning both model and design.
module tb_elapsed_timer;

  localparam int Tp   = 4;
  localparam int Maxt = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start, stop, resume, lap;
  logic [13:0] tenths_a;
  logic [15:0] bcd_a, lap_a;
  logic running_a, sat_a, tick_a;

  logic start_b, stop_b, resume_b, lap_b;
  logic [13:0] tenths_b;
  logic [15:0] bcd_b, lap_bcd_b;
  logic running_b, sat_b, tick_b;

  int total = 0;
  int bad = 0;

  elapsed_timer #(
    .TICK_PERIOD (25'd4),
    .MAX_TENTHS  (14'd25)
  ) dut_a (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .start_in      (start),
    .stop_in       (stop),
    .resume_in     (resume),
    .lap_in        (lap),
    .tenths_out    (tenths_a),
    .bcd_out       (bcd_a),
    .lap_bcd_out   (lap_a),
    .running_out   (running_a),
    .saturated_out (sat_a),
    .tick_out      (tick_a)
  );

  elapsed_timer #(
    .TICK_PERIOD (25'd1),
    .MAX_TENTHS  (14'd9999)
  ) dut_b (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .start_in      (start_b),
    .stop_in       (stop_b),
    .resume_in     (resume_b),
    .lap_in        (lap_b),
    .tenths_out    (tenths_b),
    .bcd_out       (bcd_b),
    .lap_bcd_out   (lap_bcd_b),
    .running_out   (running_b),
    .saturated_out (sat_b),
    .tick_out      (tick_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Model: mode 0 idle, 1 running, 2 paused, 3 saturated; phase = cycles spent
  // in the current 100 ms slot.
  int m_mode = 0;
  int m_count = 0;
  int m_phase = 0;
  int m_lap = 0;
  bit m_tick = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_count <= 0;
      m_phase <= 0;
      m_lap   <= 0;
      m_tick  <= 1'b0;
    end else begin
      m_tick <= 1'b0;
      if (lap) m_lap <= m_count;
      if (start) begin
        m_mode  <= 1;
        m_count <= 0;
        m_phase <= 0;
      end else if (m_mode == 1) begin
        if (stop) begin
          m_mode <= 2;
          if (m_phase != Tp - 1) m_phase <= m_phase + 1;
        end else if (m_phase == Tp - 1) begin
          m_phase <= 0;
          m_count <= m_count + 1;
          m_tick  <= 1'b1;
          if (m_count + 1 == Maxt) m_mode <= 3;
        end else begin
          m_phase <= m_phase + 1;
        end
      end else if (m_mode == 2 && resume && !stop) begin
        m_mode <= 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_tenths", 32'(tenths_a), 32'(m_count));
    chk("m_bcd", 32'(bcd_a), 32'(to_bcd(m_count)));
    chk("m_lap", 32'(lap_a), 32'(to_bcd(m_lap)));
    chk("m_running", 32'(running_a), 32'(m_mode == 1));
    chk("m_saturated", 32'(sat_a), 32'(m_mode == 3));
    chk("m_tick", 32'(tick_a), 32'(m_tick));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 start, 1 stop, 2 resume, 3 lap, 4 start on dut_b
  task automatic pulse(input int which);
    case (which)
      0: start = 1'b1;
      1: stop = 1'b1;
      2: resume = 1'b1;
      3: lap = 1'b1;
      default: start_b = 1'b1;
    endcase
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    resume = 1'b0;
    lap = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; resume = 1'b0; lap = 1'b0;
    start_b = 1'b0; stop_b = 1'b0; resume_b = 1'b0; lap_b = 1'b0;
    step(2);
    chk("rst_tenths", 32'(tenths_a), 32'd0);
    chk("rst_bcd", 32'(bcd_a), 32'd0);
    chk("rst_lap", 32'(lap_a), 32'd0);
    chk("rst_running", 32'(running_a), 32'd0);
    chk("rst_tick", 32'(tick_a), 32'd0);
    rst_n = 1'b1;

    // First tick exactly 4 cycles after the start edge, then 12 ticks
    pulse(0);
    chk("t1_running", 32'(running_a), 32'd1);
    repeat (3) begin
      step(1);
      chk("t1_no_early_tick", 32'(tick_a), 32'd0);
    end
    step(1);
    chk("t1_first_tick", 32'(tick_a), 32'd1);
    chk("t1_first_count", 32'(tenths_a), 32'd1);
    step(44);
    chk("t1_tenths12", 32'(tenths_a), 32'd12);
    chk("t1_bcd12", 32'(bcd_a), 32'h0012);
    chk("t1_running12", 32'(running_a), 32'd1);

    // Pause at count 9 with prescaler 2, hold 10 cycles, resume
    pulse(0);
    step(38);
    chk("t2_at9", 32'(tenths_a), 32'd9);
    pulse(1);
    chk("t2_paused", 32'(running_a), 32'd0);
    step(10);
    chk("t2_hold9", 32'(tenths_a), 32'd9);
    chk("t2_hold_bcd", 32'(bcd_a), 32'h0009);
    pulse(2);
    chk("t2_resumed", 32'(running_a), 32'd1);
    chk("t2_no_tick_yet", 32'(tick_a), 32'd0);
    step(1);
    chk("t2_tick_after_resume", 32'(tick_a), 32'd1);
    chk("t2_count10", 32'(tenths_a), 32'd10);

    // Saturation at 25
    step(60);
    chk("t3_sat", 32'(sat_a), 32'd1);
    chk("t3_not_running", 32'(running_a), 32'd0);
    chk("t3_tenths25", 32'(tenths_a), 32'd25);
    chk("t3_bcd25", 32'(bcd_a), 32'h0025);
    repeat (20) begin
      step(1);
      chk("t3_frozen_tick", 32'(tick_a), 32'd0);
      chk("t3_frozen_count", 32'(tenths_a), 32'd25);
    end
    pulse(0);
    chk("t3_restart_count", 32'(tenths_a), 32'd0);
    chk("t3_restart_running", 32'(running_a), 32'd1);
    chk("t3_restart_unsat", 32'(sat_a), 32'd0);

    // Lap at 7, run to 15, restart keeps lap
    step(28);
    chk("t4_at7", 32'(tenths_a), 32'd7);
    pulse(3);
    step(31);
    chk("t4_lap7", 32'(lap_a), 32'h0007);
    chk("t4_bcd15", 32'(bcd_a), 32'h0015);
    pulse(0);
    chk("t4_lap_kept", 32'(lap_a), 32'h0007);
    chk("t4_cleared", 32'(bcd_a), 32'h0000);

    // Start beats stop; stop on a tick cycle suppresses the increment
    step(20);
    chk("t5_at5", 32'(tenths_a), 32'd5);
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    chk("t5_start_wins_run", 32'(running_a), 32'd1);
    chk("t5_start_wins_count", 32'(tenths_a), 32'd0);
    step(11);
    chk("t5_at2", 32'(tenths_a), 32'd2);
    pulse(1);
    chk("t5_stop_on_tick_count", 32'(tenths_a), 32'd2);
    chk("t5_stop_on_tick_tick", 32'(tick_a), 32'd0);
    pulse(2);
    chk("t5_resume_count", 32'(tenths_a), 32'd2);
    step(1);
    chk("t5_deferred_tick", 32'(tick_a), 32'd1);
    chk("t5_count3", 32'(tenths_a), 32'd3);

    // Asynchronous reset mid-run at count 11
    pulse(0);
    step(44);
    chk("t6_at11", 32'(tenths_a), 32'd11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tenths", 32'(tenths_a), 32'd0);
    chk("t6_rst_bcd", 32'(bcd_a), 32'd0);
    chk("t6_rst_lap", 32'(lap_a), 32'd0);
    chk("t6_rst_running", 32'(running_a), 32'd0);
    chk("t6_rst_sat", 32'(sat_a), 32'd0);
    chk("t6_rst_tick", 32'(tick_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BCD carry chain with a tick every cycle
    pulse(4);
    step(99);
    chk("t6b_tenths99", 32'(tenths_b), 32'd99);
    chk("t6b_bcd99", 32'(bcd_b), 32'h0099);
    step(1);
    chk("t6b_tenths100", 32'(tenths_b), 32'd100);
    chk("t6b_bcd100", 32'(bcd_b), 32'h0100);
    chk("t6b_running", 32'(running_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
